ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between two requesters: requester 0 is the core load/store unit, requester 1 is the loader/debug path.
- Round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse per requester.
- The RAM has no byte enables, so partial-strobe writes are done as a read-merge-write sequence.
- Sits between the LSU/loader and RAM port B; port A stays dedicated to instruction fetch.

Parameters:
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- ADDR_WIDTH, 8, RAM word-address width (word addressing, not byte).
- STRB_WIDTH, DATA_WIDTH/8, derived localparam; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- reqN_valid  in  1  request valid, N = 0 and 1
- reqN_ready  out  1  request accepted this cycle when valid && ready
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_wstrb  in  STRB_WIDTH  byte strobes; ignored for reads
- rspN_valid  out  1  one-cycle completion pulse; no backpressure
- rspN_rdata  out  DATA_WIDTH  read data, valid only with rspN_valid on a read
- ram_wr_en  out  1  to RAM port write enable
- ram_addr  out  ADDR_WIDTH  to RAM port address
- ram_wdata  out  DATA_WIDTH  to RAM port input data
- ram_rdata  in  DATA_WIDTH  from RAM port output data: registered, 1-cycle latency, holds its value on write cycles

Behaviour:
- Reset (async, any state):
  - state = IDLE; last_grant = 1, so req0 wins the first contention.
  - rsp0_valid = rsp1_valid = 0; all pending registers cleared.
  - While rst = 1: req0_ready = req1_ready = 0 and ram_wr_en = 0.
  - An in-flight RMW is abandoned with no RAM write and no response.
- FSM states: IDLE, MERGE.
- IDLE arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the one not equal to last_grant.
  - reqN_ready = grant[N], combinational; the non-granted requester sees ready = 0.
  - On accept: last_grant <= N; latch requester id, op type, addr, wdata and wstrb.
- Accepted read (cycle T):
  - In T: ram_addr = reqN_addr, ram_wr_en = 0.
  - In T+1: rspN_valid = 1, rspN_rdata = ram_rdata (combinational pass-through). FSM stays in IDLE.
- Accepted write with wstrb all ones (cycle T):
  - In T: ram_wr_en = 1, ram_addr = addr, ram_wdata = wdata.
  - rspN_valid = 1 in T+1. Stays in IDLE.
- Accepted write with wstrb all zeros: no RAM access (ram_wr_en = 0); rspN_valid = 1 in T+1.
- Accepted partial write (cycle T):
  - In T: issue a read of addr; go to MERGE.
  - MERGE (T+1): for each byte b, ram_wdata byte b = wstrb[b] ? wdata byte b : ram_rdata byte b. Drive ram_wr_en = 1, ram_addr = latched addr. Both ready = 0.
  - T+2: rspN_valid = 1; state returns to IDLE.
- Throughput and ordering:
  - Back-to-back reads and full writes are accepted every cycle.
  - A new request is accepted in IDLE in the same cycle as the previous response pulse.
  - A read issued the cycle after a write to the same address returns the new data (the RAM updates at the write edge).
- Outputs when idle with no accept: ram_wr_en = 0; ram_addr and ram_wdata hold their last values (don't care, but stable).
- rspN_valid is registered; at most one of rsp0/rsp1 is high in any cycle.
- No starvation: with both requesters valid continuously, grants alternate 0,1,0,1.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum (IDLE, MERGE);
  - requester-id typedef;
  - byte-merge function (old, new, strb).
- One natural sub-module: rr_arbiter2, the two-way round-robin grant logic with its last_grant register.
- Datapath and FSM remain in ram_port_arbiter.

Test Plan:
- Reset then idle: rst pulse mid-MERGE of a 0x3 strobe write to addr 5 -> no write to addr 5, no rsp, both ready = 0 during rst, state IDLE after.
- Full write then read: req0 write addr 0x10 data 0xDEADBEEF strb 0xF at T -> rsp0_valid at T+1. Read addr 0x10 at T+1 -> rsp0_rdata = 0xDEADBEEF at T+2.
- Partial write: mem[0x20] = 0x11223344; req1 write 0xAABBCCDD strb 0b0101 -> ram_wr_en only at T+1 with data 0x11BB33DD; rsp1 at T+2; later read returns 0x11BB33DD.
- Contention: both valid reads every cycle from reset, addrs 1 (req0) / 2 (req1) -> grants 0,1,0,1; each rsp carries the correct mem contents.
- Blocking: req0 partial write at T, req1 read valid from T -> req1_ready = 0 at T+1 (MERGE); req1 accepted at T+2.
- Zero strobe: req0 write strb 0x0 to addr 7 -> ram_wr_en stays 0; rsp0_valid at T+1; mem[7] unchanged.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the RAM port-B arbiter.
// State encoding, requester id type and the byte-merge helper.
package ram_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  typedef logic req_id_t;

  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       strb
  );
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic with its last-grant register.
// Ports: clk, rst, en_i (arbitration allowed), req_i, grant_o.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  req_id_t last_q;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11)
        grant_o = last_q ? 2'b01 : 2'b10;
      else
        grant_o = req_i;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= 1'b1;
    else if (|grant_o)
      last_q <= grant_o[1];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port B between the LSU (req0) and loader/debug (req1).
// Ports: two valid/ready request ports, two response pulses, RAM port.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_we,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [1:0]              rsp_q, rsp_d;
  req_id_t                 id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic [1:0]              grant;
  logic                    arb_en;
  logic                    acc;
  req_id_t                 sel;
  logic                    a_we;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic [STRB_WIDTH-1:0]   a_strb;
  logic [DATA_WIDTH-1:0]   merged;

  assign arb_en = !rst && (state_q == IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .req_i   ({req1_valid, req0_valid}),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign acc     = |grant;
  assign sel     = grant[1];
  assign a_we    = sel ? req1_we    : req0_we;
  assign a_addr  = sel ? req1_addr  : req0_addr;
  assign a_wdata = sel ? req1_wdata : req0_wdata;
  assign a_strb  = sel ? req1_wstrb : req0_wstrb;

  // Old word arrives from the RAM read issued in the accept cycle.
  for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_merge
    assign merged[8*b +: 8] = merge_byte(ram_rdata[8*b +: 8],
                                         wdata_q[8*b +: 8],
                                         wstrb_q[b]);
  end

  always_comb begin
    state_d   = state_q;
    rsp_d     = 2'b00;
    ram_wr_en = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = hold_q;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            ram_addr = a_addr;
            if (!a_we) begin
              rsp_d[sel] = 1'b1;
            end else if (&a_strb) begin
              ram_wr_en  = 1'b1;
              ram_wdata  = a_wdata;
              rsp_d[sel] = 1'b1;
            end else if (~|a_strb) begin
              rsp_d[sel] = 1'b1;
            end else begin
              state_d = MERGE;
            end
          end
        end
        MERGE: begin
          ram_wr_en   = 1'b1;
          ram_wdata   = merged;
          rsp_d[id_q] = 1'b1;
          state_d     = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rsp_q   <= 2'b00;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      hold_q  <= ram_wdata;
      if (acc) begin
        id_q    <= sel;
        addr_q  <= a_addr;
        wdata_q <= a_wdata;
        wstrb_q <= a_strb;
      end
    end
  end

  assign rsp0_valid = rsp_q[0];
  assign rsp1_valid = rsp_q[1];
  assign rsp0_rdata = ram_rdata;
  assign rsp1_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM model.
// Expected values are hand-computed constants.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_wstrb;
  logic        req1_valid, req1_ready, req1_we;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic [3:0]  req1_wstrb;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        ram_wr_en;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];
  int          wr5;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wstrb (req0_wstrb),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wstrb (req1_wstrb),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_wr_en  (ram_wr_en),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Registered-read RAM; output holds on write cycles.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_addr] <= ram_wdata;
      if (ram_addr == 8'd5) wr5 <= wr5 + 1;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr5 = 0;
    ram_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h01] = 32'hA1A1A1A1;
    mem[8'h02] = 32'hB2B2B2B2;
    mem[8'h05] = 32'h55555555;
    mem[8'h07] = 32'h77777777;
    mem[8'h20] = 32'h11223344;
    mem[8'h30] = 32'hCAFEF00D;
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
    req0_wdata = '0;   req0_wstrb = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
    req1_wdata = '0;   req1_wstrb = '0;
    cyc();
    mid();
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_wr_en", 32'(ram_wr_en), 0);
    check("rst_rsp0", 32'(rsp0_valid), 0);

    // Contention: both reading every cycle
    cyc(); rst = 1'b0;
    mid();
    check("ct0_ready0", 32'(req0_ready), 1);
    check("ct0_ready1", 32'(req1_ready), 0);
    check("ct0_addr", 32'(ram_addr), 32'h01);
    cyc(); mid();
    check("ct1_ready1", 32'(req1_ready), 1);
    check("ct1_ready0", 32'(req0_ready), 0);
    check("ct1_rsp0", 32'(rsp0_valid), 1);
    check("ct1_rdata0", rsp0_rdata, 32'hA1A1A1A1);
    check("ct1_rsp1", 32'(rsp1_valid), 0);
    cyc(); mid();
    check("ct2_ready0", 32'(req0_ready), 1);
    check("ct2_rsp1", 32'(rsp1_valid), 1);
    check("ct2_rdata1", rsp1_rdata, 32'hB2B2B2B2);
    check("ct2_rsp0", 32'(rsp0_valid), 0);
    cyc(); mid();
    check("ct3_ready1", 32'(req1_ready), 1);
    check("ct3_rsp0", 32'(rsp0_valid), 1);
    check("ct3_rdata0", rsp0_rdata, 32'hA1A1A1A1);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    check("ct4_rsp1", 32'(rsp1_valid), 1);
    check("ct4_rdata1", rsp1_rdata, 32'hB2B2B2B2);
    cyc(); mid();
    check("ct5_rsp0", 32'(rsp0_valid), 0);
    check("ct5_rsp1", 32'(rsp1_valid), 0);

    // Full write then read-after-write
    cyc();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10;
    req0_wdata = 32'hDEADBEEF; req0_wstrb = 4'hF;
    mid();
    check("fw_ready0", 32'(req0_ready), 1);
    check("fw_wr_en", 32'(ram_wr_en), 1);
    check("fw_addr", 32'(ram_addr), 32'h10);
    check("fw_wdata", ram_wdata, 32'hDEADBEEF);
    cyc(); req0_we = 1'b0;
    mid();
    check("fw_rsp0", 32'(rsp0_valid), 1);
    check("fr_ready0", 32'(req0_ready), 1);
    check("fr_wr_en", 32'(ram_wr_en), 0);
    cyc(); req0_valid = 1'b0;
    mid();
    check("fr_rsp0", 32'(rsp0_valid), 1);
    check("fr_rdata0", rsp0_rdata, 32'hDEADBEEF);

    // Partial write by req1
    cyc();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20;
    req1_wdata = 32'hAABBCCDD; req1_wstrb = 4'b0101;
    mid();
    check("pw_ready1", 32'(req1_ready), 1);
    check("pw_t_wr_en", 32'(ram_wr_en), 0);
    check("pw_t_addr", 32'(ram_addr), 32'h20);
    cyc(); req1_valid = 1'b0;
    mid();
    check("pw_m_wr_en", 32'(ram_wr_en), 1);
    check("pw_m_addr", 32'(ram_addr), 32'h20);
    check("pw_m_wdata", ram_wdata, 32'h11BB33DD);
    check("pw_m_rsp1", 32'(rsp1_valid), 0);
    cyc(); mid();
    check("pw_rsp1", 32'(rsp1_valid), 1);
    check("pw_wr_en2", 32'(ram_wr_en), 0);
    cyc(); req1_valid = 1'b1; req1_we = 1'b0;
    mid();
    check("pr_ready1", 32'(req1_ready), 1);
    cyc(); req1_valid = 1'b0;
    mid();
    check("pr_rsp1", 32'(rsp1_valid), 1);
    check("pr_rdata1", rsp1_rdata, 32'h11BB33DD);

    // Blocking during MERGE
    cyc();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h30;
    req0_wdata = 32'h12345678; req0_wstrb = 4'b1000;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
    mid();
    check("bk_ready0", 32'(req0_ready), 1);
    check("bk_ready1", 32'(req1_ready), 0);
    cyc(); req0_valid = 1'b0;
    mid();
    check("bk_m_ready1", 32'(req1_ready), 0);
    check("bk_m_wr_en", 32'(ram_wr_en), 1);
    check("bk_m_wdata", ram_wdata, 32'h12FEF00D);
    cyc(); mid();
    check("bk_ready1_acc", 32'(req1_ready), 1);
    check("bk_rsp0", 32'(rsp0_valid), 1);
    check("bk_addr", 32'(ram_addr), 32'h02);
    cyc(); req1_valid = 1'b0;
    mid();
    check("bk_rsp1", 32'(rsp1_valid), 1);
    check("bk_rdata1", rsp1_rdata, 32'hB2B2B2B2);
    check("bk_rsp0_off", 32'(rsp0_valid), 0);

    // Zero strobe write
    cyc();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h07;
    req0_wdata = 32'h0; req0_wstrb = 4'h0;
    mid();
    check("zs_ready0", 32'(req0_ready), 1);
    check("zs_wr_en", 32'(ram_wr_en), 0);
    cyc(); req0_we = 1'b0;
    mid();
    check("zs_rsp0", 32'(rsp0_valid), 1);
    check("zs_wr_en2", 32'(ram_wr_en), 0);
    cyc(); req0_valid = 1'b0;
    mid();
    check("zs_rdata0", rsp0_rdata, 32'h77777777);

    // Reset in the middle of MERGE
    cyc();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h05;
    req0_wdata = 32'hFFFFFFFF; req0_wstrb = 4'h3;
    mid();
    check("rm_ready0", 32'(req0_ready), 1);
    cyc(); rst = 1'b1; req1_valid = 1'b1;
    mid();
    check("rm_wr_en", 32'(ram_wr_en), 0);
    check("rm_ready0", 32'(req0_ready), 0);
    check("rm_ready1", 32'(req1_ready), 0);
    cyc(); mid();
    check("rm_rsp0", 32'(rsp0_valid), 0);
    cyc(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    check("rm_rsp0_after", 32'(rsp0_valid), 0);
    check("rm_wr_after", 32'(ram_wr_en), 0);
    cyc(); req0_valid = 1'b1; req0_we = 1'b0;
    mid();
    check("rm_idle_ready0", 32'(req0_ready), 1);
    cyc(); req0_valid = 1'b0;
    mid();
    check("rm_rdata0", rsp0_rdata, 32'h55555555);
    check("rm_no_wr5", 32'(wr5), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
